// File: rtl/lift_req_queue.sv
// rtl/lift_req_queue.sv - hall-call request FIFO with duplicate suppression and lamp outputs
module lift_req_queue #(
    parameter int DEPTH = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] btn,
    input  logic       pop,
    output logic [2:0] req,
    output logic       qEmpty,
    output logic [5:0] pending,
    output logic [2:0] count
);

    logic [5:0] btn_prev;
    logic [5:0] queued;
    logic [2:0] mem [0:DEPTH-1];
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;

    logic [5:0] btn_edge;
    logic       pop_ok;
    logic [5:0] pop_clear;
    logic       enq_valid;
    logic [2:0] enq_idx;
    logic [5:0] enq_set;

    assign btn_edge = btn & ~btn_prev;
    assign pop_ok   = pop && (count != 3'd0);

    always_comb begin
        pop_clear = 6'b0;
        for (int i = 0; i < 6; i++) begin
            pop_clear[i] = pop_ok && (mem[rd_ptr] == 3'(i + 1));
        end
    end

    // Lowest waiting index wins; descending scan lets the lowest overwrite.
    always_comb begin
        enq_valid = 1'b0;
        enq_idx   = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (pending[i] && !queued[i]) begin
                enq_valid = 1'b1;
                enq_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        enq_set = 6'b0;
        if (enq_valid) begin
            enq_set[enq_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev <= 6'b111111;
            pending  <= 6'b0;
            queued   <= 6'b0;
            wr_ptr   <= 3'd0;
            rd_ptr   <= 3'd0;
            count    <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 3'd0;
            end
        end else begin
            btn_prev <= btn;
            // A fresh edge on the popped button re-arms its lamp (set wins).
            pending  <= (pending & ~pop_clear) | btn_edge;
            queued   <= (queued & ~pop_clear) | enq_set;
            if (enq_valid) begin
                mem[wr_ptr] <= enq_idx + 3'd1;
                wr_ptr      <= (wr_ptr == 3'(DEPTH - 1)) ? 3'd0 : wr_ptr + 3'd1;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == 3'(DEPTH - 1)) ? 3'd0 : rd_ptr + 3'd1;
            end
            if (enq_valid && !pop_ok) begin
                count <= count + 3'd1;
            end else if (!enq_valid && pop_ok) begin
                count <= count - 3'd1;
            end
        end
    end

    assign qEmpty = (count == 3'd0);
    assign req    = qEmpty ? 3'd0 : mem[rd_ptr];

endmodule

// File: tb/tb_lift_req_queue.sv
// tb/tb_lift_req_queue.sv - randomized scoreboard bench for lift_req_queue
module tb_lift_req_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] btn;
    logic       pop;
    logic [2:0] req;
    logic       qEmpty;
    logic [5:0] pending;
    logic [2:0] count;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0] req;
        logic       qe;
        logic [5:0] pend;
        logic [2:0] cnt;
    } exp_t;

    exp_t       sb[$];
    exp_t       mx;
    logic [5:0] m_prev;
    logic [5:0] m_pend;
    int         m_fifo[$];

    lift_req_queue #(.DEPTH(6)) dut (
        .clk(clk), .rst(rst), .btn(btn), .pop(pop),
        .req(req), .qEmpty(qEmpty), .pending(pending), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_fifo(input int code);
        foreach (m_fifo[k]) if (m_fifo[k] == code) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: a queue of codes plus a lamp set; all decisions use pre-edge state.
    task automatic model_update();
        logic [5:0] e;
        int cand;
        int h;
        exp_t x;
        if (rst) begin
            m_prev = 6'b111111;
            m_pend = 6'b0;
            m_fifo.delete();
        end else begin
            e = btn & ~m_prev;
            cand = -1;
            for (int i = 0; i < 6; i++)
                if (cand < 0 && m_pend[i] && !in_fifo(i + 1)) cand = i;
            if (pop && m_fifo.size() > 0) begin
                h = m_fifo.pop_front();
                m_pend[h - 1] = 1'b0;
            end
            if (cand >= 0) m_fifo.push_back(cand + 1);
            m_pend = m_pend | e;
            m_prev = btn;
        end
        x.req  = (m_fifo.size() > 0) ? 3'(m_fifo[0]) : 3'd0;
        x.qe   = (m_fifo.size() == 0);
        x.pend = m_pend;
        x.cnt  = 3'(m_fifo.size());
        sb.push_back(x);
    endtask

    task automatic step(input logic [5:0] b, input logic p);
        btn = b;
        pop = p;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(6'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mx = sb.pop_front();
            chk("req", int'(req), int'(mx.req));
            chk("qEmpty", int'(qEmpty), int'(mx.qe));
            chk("pending", int'(pending), int'(mx.pend));
            chk("count", int'(count), int'(mx.cnt));
            checks++;
            if (count > 3'd6) begin
                failures++;
                $display("FAIL count_bound actual=%0d expected<=6", count);
            end
        end
    end

    initial begin
        int to;
        btn = 6'b0;
        pop = 1'b0;
        rst = 1'b1;
        step(6'b0, 1'b0);
        step(6'b0, 1'b0);
        rst = 1'b0;
        idle(2);
        // held through reset: no capture until released and re-pressed
        rst = 1'b1;
        step(6'b000100, 1'b0);
        step(6'b000100, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(6'b000100, 1'b0);
        idle(2);
        // single press then pop
        step(6'b000010, 1'b0);
        idle(3);
        step(6'b0, 1'b1);
        idle(1);
        // duplicate suppression
        for (int i = 0; i < 3; i++) begin
            step(6'b010000, 1'b0);
            step(6'b0, 1'b0);
        end
        step(6'b0, 1'b1);
        idle(2);
        // simultaneous burst
        step(6'b101001, 1'b0);
        idle(4);
        for (int i = 0; i < 3; i++) step(6'b0, 1'b1);
        idle(1);
        // ordering and pointer wrap
        step(6'b100000, 1'b0); step(6'b0, 1'b0);
        step(6'b000100, 1'b0); step(6'b0, 1'b0);
        step(6'b000001, 1'b0); step(6'b0, 1'b0);
        step(6'b010000, 1'b0); step(6'b0, 1'b0);
        step(6'b0, 1'b1); step(6'b0, 1'b1);
        step(6'b000010, 1'b0); step(6'b0, 1'b0);
        step(6'b001000, 1'b0); step(6'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 5; i++) step(6'b0, 1'b1);
        idle(1);
        // pop/press collision on code 3
        step(6'b000100, 1'b0);
        idle(3);
        step(6'b000100, 1'b1);
        idle(3);
        step(6'b0, 1'b1);
        idle(1);
        // randomized traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 499) == 0);
            step(6'($urandom) & 6'($urandom), ($urandom_range(0, 2) == 0));
        end
        rst = 1'b0;
        idle(8);
        for (int i = 0; i < 8; i++) step(6'b0, 1'b1);
        to = 0;
        while (sb.size() > 0 && to < 10) begin
            @(posedge clk);
            to++;
        end
        checks++;
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lift_req_queue.md
# lift_req_queue

Hall-call request queue feeding the lift controller FSM. Captures presses on the six hall buttons, suppresses duplicates, and presents requests one at a time, oldest first, as a 3-bit request code with an empty flag. The controller consumes the head entry and returns a single-cycle pop strobe. Also drives the six hall-button lamps.

## Interface
- DEPTH, 6, FIFO entries; equals the number of distinct request codes, so the queue cannot overflow.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- btn  in  6  raw hall buttons, level, 1=pressed: [0]=1u, [1]=2u, [2]=3u, [3]=2d, [4]=3d, [5]=4d.
- pop  in  1  one-cycle strobe from the controller: head entry consumed.
- req  out 3  head request code = button index+1 (1=1u … 6=4d); 3'b000 when empty.
- qEmpty out 1  1 when the FIFO holds no entries.
- pending out 6  lamp per button; 1 from capture until that request is popped.
- count out 3  FIFO occupancy, 0..6.

## Operation
- Edge detect: btn_prev registered each cycle. edge[i] = btn[i] & ~btn_prev[i]. Holding a button produces one capture.
- Capture: on edge[i], pending[i] is set. An edge for an already-pending button is absorbed and adds no second entry.
- Enqueue: a queued[5:0] register marks codes resident in the FIFO. Each cycle, the lowest index i with pending[i] & ~queued[i] is written at wr_ptr as code i+1, and queued[i] is set. Only one enqueue happens per cycle. Several simultaneous edges therefore drain in ascending index order over consecutive cycles.
- Dequeue: pop=1 with count>0 advances rd_ptr and clears pending and queued for the head code. pop with count=0 is ignored and no state changes.
- Simultaneous pop of code c and a new edge on the same button: the set wins. pending[c] stays 1, queued[c] is cleared, and c is re-enqueued at the tail on a later cycle.
- Simultaneous enqueue and dequeue: both pointers advance and count is unchanged.
- Pointers are 3 bits and wrap 5→0. count increments on enqueue only, decrements on pop only, and is unchanged when both occur.
- Invariant: count == popcount(queued) ≤ 6. Write with count==6 is unreachable; the bench asserts it.
- Output decode: req = mem[rd_ptr] when count≠0, else 3'b000. qEmpty = (count==0). Both are combinational from registers, with no input-to-output path.
- Reset: pointers, count, pending, queued and mem all go to 0. btn_prev loads 6'b111111, so a button held through reset is not captured until released and pressed again. Reset mid-operation discards all requests.

## Timing
- Outputs after reset: req=3'b000, qEmpty=1, pending=6'b0, count=0.
- btn[i] first sampled high at posedge k sets pending[i] after edge k.
- If no lower index is waiting, the entry is enqueued at posedge k+1, so qEmpty=0 and req=i+1 after edge k+1. Press-to-visible latency is 2 cycles.
- pop sampled at posedge k moves req to the next entry, or to 0 with qEmpty=1, after edge k. pending clears at the same edge.
- A burst of n simultaneous edges is fully queued n cycles after capture.

## Test plan
- Reset: with btn=0 then rst=1 for 2 cycles, expect req=0, qEmpty=1, pending=0, count=0. Also hold btn[2]=1 through reset and release rst: expect no capture.
- Single press: btn[1] high for 1 cycle at posedge 10 gives pending=6'b000010 after 10, and req=2, qEmpty=0, count=1 after 11. Then pop at posedge 14 gives req=0, qEmpty=1, pending=0.
- Duplicate suppression: press btn[4] three times, separated by releases, before any pop. Expect count=1 and req=5; one pop empties the queue.
- Simultaneous burst: btn=6'b101001 rises in one cycle. Over the following cycles count goes 1,2,3, and pops return codes 1, 4, 6 in that order.
- Ordering/wrap: press 6, 3, 1, 5, 2, 4 on separate cycles, popping two entries after the fourth press, then pop all. Expect FIFO order 6,3,1,5,2,4, pointers wrapping past 5, and count never above 6.
- Pop/press collision: with only code 3 queued, assert pop and a fresh btn[2] edge in the same cycle. Expect count 1→0 and then back to 1, req=3 again, and pending[2] never dropping to 0.
